// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit shifter and the future receiver checker.
// Holds the line levels, the TX state encoding, the frame-length helper and the
// parity helper.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Widest data word any UART block in this slice handles.
  localparam int unsigned MAX_DATA_W = 9;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } tx_state_e;

  // Total bits on the line for one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return 1 + data_w + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Data is zero-extended to MAX_DATA_W by callers; extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_shifter_if.sv
// Strobe / status bundle between the UART TX FSM and the TX shifter.
//   load, shift, data_in : FSM -> shifter
//   tx_out               : serial line
//   frame_done, active, bit_index : shifter -> FSM status
// master = FSM side, slave = shifter side.
interface uart_tx_shifter_if #(
  parameter int unsigned DATA_W = 8
);

  logic              load;
  logic              shift;
  logic [DATA_W-1:0] data_in;
  logic              tx_out;
  logic              frame_done;
  logic              active;
  logic [3:0]        bit_index;

  modport master (
    output load, shift, data_in,
    input  tx_out, frame_done, active, bit_index
  );

  modport slave (
    input  load, shift, data_in,
    output tx_out, frame_done, active, bit_index
  );

endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity generator.
//   data_i   : data word (DATA_W bits)
//   odd_i    : 0 = even parity, 1 = odd parity
//   parity_o : parity bit to append so the frame has the requested parity
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              odd_i,
  output logic              parity_o
);

  logic [MAX_DATA_W-1:0] data_ext;

  always_comb begin
    data_ext                = '0;
    data_ext[DATA_W-1:0]    = data_i;
    parity_o                = parity_bit(data_ext, odd_i);
  end

endmodule

// File: rtl/uart_tx_shifter.sv
// UART transmit datapath. Captures a word on load, serialises
// {stop bits, parity, data, start} LSB first on each shift strobe, and reports
// frame progress back to the TX FSM.
//   baud_rate_tx : bit clock, all logic on its rising edge
//   rst          : synchronous active-high reset
//   tx_if.load / shift / data_in : strobes and word from the FSM
//   tx_if.tx_out     : serial line, idle high
//   tx_if.frame_done : one-cycle pulse when the last stop bit has completed
//   tx_if.active     : high while a frame is in progress
//   tx_if.bit_index  : index of the bit currently on tx_out (0 = start bit)
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 baud_rate_tx,
  input  logic                 rst,
  uart_tx_shifter_if.slave     tx_if
);

  localparam int unsigned FrameLen = frame_len(DATA_W, PARITY_EN, STOP_BITS);
  localparam logic [3:0]  LastIdx  = 4'(FrameLen - 1);
  localparam logic        OddPar   = (PARITY_ODD != 0);

  tx_state_e             state_q, state_d;
  logic [FrameLen-1:0]   frame_q, frame_d;
  logic [3:0]            idx_q, idx_d;
  logic                  done_q, done_d;

  logic                  parity;
  logic [FrameLen-1:0]   load_frame;

  uart_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data_i   (tx_if.data_in),
    .odd_i    (OddPar),
    .parity_o (parity)
  );

  // Stop bits fill the top of the register; parity (if any) sits just above the data.
  always_comb begin
    load_frame               = {FrameLen{STOP_LEVEL}};
    load_frame[0]            = START_LEVEL;
    load_frame[DATA_W:1]     = tx_if.data_in;
    if (PARITY_EN != 0) begin
      load_frame[DATA_W+1] = parity;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (tx_if.load) begin
      // Load wins over shift and silently aborts any frame in flight.
      state_d = StBusy;
      frame_d = load_frame;
      idx_d   = '0;
    end else if (tx_if.shift) begin
      unique case (state_q)
        StBusy: begin
          if (idx_q == LastIdx) begin
            // Last stop bit has had its full bit period; end the frame.
            state_d = StIdle;
            frame_d = {FrameLen{IDLE_LEVEL}};
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            frame_d = {IDLE_LEVEL, frame_q[FrameLen-1:1]};
            idx_d   = idx_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge baud_rate_tx) begin
    if (rst) begin
      state_q <= StIdle;
      frame_q <= {FrameLen{IDLE_LEVEL}};
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // tx_out is the register LSB, so the line level is always a flop output.
  assign tx_if.tx_out     = frame_q[0];
  assign tx_if.active     = (state_q == StBusy);
  assign tx_if.bit_index  = idx_q;
  assign tx_if.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Self-checking bench for uart_tx_shifter. DUT A: 8 data bits, even parity, 1 stop.
// DUT B: 8 data bits, odd parity, 2 stops. Frame bits are queued when a load is
// driven and popped as shifts are driven; every cycle the DUT outputs are compared.
module tb_uart_tx_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       drv_load, drv_shift, sel;
  logic [7:0] drv_data;

  uart_tx_shifter_if #(.DATA_W(8)) if_a ();
  uart_tx_shifter_if #(.DATA_W(8)) if_b ();

  assign if_a.load    = drv_load & ~sel;
  assign if_a.shift   = drv_shift & ~sel;
  assign if_a.data_in = drv_data;
  assign if_b.load    = drv_load & sel;
  assign if_b.shift   = drv_shift & sel;
  assign if_b.data_in = drv_data;

  uart_tx_shifter #(
    .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut_a (
    .baud_rate_tx (clk),
    .rst          (rst),
    .tx_if        (if_a)
  );

  uart_tx_shifter #(
    .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u_dut_b (
    .baud_rate_tx (clk),
    .rst          (rst),
    .tx_if        (if_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit m_bits[$];
  int m_idx    = 0;
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_odd    = 1'b0;
  int m_stops  = 1;

  logic       o_tx, o_act, o_done, o_prev_done;
  logic [3:0] o_idx;
  int         done_cnt;

  task automatic model_step(input logic ld, input logic sh, input logic [7:0] d,
                            input logic r);
    int n;
    n = 1 + 8 + 1 + m_stops;
    m_done = 1'b0;
    if (r) begin
      m_bits.delete();
      m_active = 1'b0;
      m_idx    = 0;
    end else if (ld) begin
      m_bits.delete();
      m_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
      m_bits.push_back((^d) ^ m_odd);
      for (int i = 0; i < m_stops; i++) m_bits.push_back(1'b1);
      m_active = 1'b1;
      m_idx    = 0;
    end else if (sh && m_active) begin
      if (m_idx == n - 1) begin
        m_bits.delete();
        m_active = 1'b0;
        m_idx    = 0;
        m_done   = 1'b1;
      end else begin
        void'(m_bits.pop_front());
        m_idx++;
      end
    end
  endtask

  task automatic step(input logic ld, input logic sh, input logic [7:0] d, input logic r);
    logic exp_tx;
    @(negedge clk);
    drv_load  = ld;
    drv_shift = sh;
    drv_data  = d;
    rst       = r;
    model_step(ld, sh, d, r);
    @(posedge clk);
    #1;
    o_prev_done = o_done;
    o_tx   = sel ? if_b.tx_out     : if_a.tx_out;
    o_act  = sel ? if_b.active     : if_a.active;
    o_done = sel ? if_b.frame_done : if_a.frame_done;
    o_idx  = sel ? if_b.bit_index  : if_a.bit_index;
    exp_tx = m_active ? m_bits[0] : 1'b1;
    chk("tx_out", 32'(o_tx), 32'(exp_tx));
    chk("active", 32'(o_act), 32'(m_active));
    chk("bit_index", 32'(o_idx), 32'(m_idx));
    chk("frame_done", 32'(o_done), 32'(m_done));
    chk("done_back_to_back", 32'(o_prev_done & o_done), 32'd0);
    if (o_done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic shift1();
    step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  logic [10:0] seq;
  logic [10:0] exp_seq;
  int          shifts_to_done;

  initial begin
    rst = 1'b1; drv_load = 1'b0; drv_shift = 1'b0; drv_data = '0; sel = 1'b0;
    o_done = 1'b0;
    done_cnt = 0;

    // Reset, then idle with no strobes
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(20);

    // 0xA5 frame, even parity, 1 stop
    done_cnt = 0;
    exp_seq  = 11'b10101001010;
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    seq[0] = o_tx;
    for (int i = 1; i <= 10; i++) begin
      shift1();
      seq[i] = o_tx;
    end
    chk("a5_sequence", 32'(seq), 32'(exp_seq));
    chk("a5_no_done_before_last_shift", done_cnt, 0);
    shift1();
    chk("a5_done_pulse", 32'(o_done), 32'd1);
    idle(2);
    chk("a5_idle_after", 32'(o_act), 32'd0);
    chk("a5_done_count", done_cnt, 1);

    // Abort: load 0x0F, 3 shifts, then load 0xF0 with shift in the same cycle
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h0F, 1'b0);
    repeat (3) shift1();
    step(1'b1, 1'b1, 8'hF0, 1'b0);
    chk("abort_start_bit", 32'(o_tx), 32'd0);
    chk("abort_index", 32'(o_idx), 32'd0);
    repeat (11) shift1();
    idle(2);
    chk("abort_done_count", done_cnt, 1);

    // Reset mid-frame at bit_index 5, then shifts are ignored
    done_cnt = 0;
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    repeat (5) shift1();
    chk("pre_reset_index", 32'(o_idx), 32'd5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_tx", 32'(o_tx), 32'd1);
    chk("reset_active", 32'(o_act), 32'd0);
    repeat (3) shift1();
    chk("reset_done_count", done_cnt, 0);

    // Shifts while idle
    done_cnt = 0;
    repeat (5) shift1();
    chk("idle_shift_done_count", done_cnt, 0);

    // Stalled frame: 3 idle cycles between shifts
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    for (int i = 0; i < 11; i++) begin
      idle(3);
      shift1();
    end
    idle(2);
    chk("stall_done_count", done_cnt, 1);

    // A few random frames
    for (int f = 0; f < 3; f++) begin
      done_cnt = 0;
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      repeat (11) shift1();
      idle(1);
      chk("rand_done_count", done_cnt, 1);
    end

    // DUT B: odd parity, two stop bits
    sel = 1'b1; m_odd = 1'b1; m_stops = 2;
    done_cnt = 0;
    shifts_to_done = 0;
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    for (int i = 1; i <= 9; i++) shift1();
    chk("odd_parity_index", 32'(o_idx), 32'd9);
    chk("odd_parity_bit", 32'(o_tx), 32'd1);
    shifts_to_done = 9;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      shift1();
      shifts_to_done++;
    end
    chk("two_stop_shifts_to_done", shifts_to_done, 12);
    idle(2);
    chk("two_stop_done_count", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
